// File: rtl/pattern_detector_param.sv
// Serial bit-pattern detector: shifts qualified bits into a PAT_W-bit history and
// compares it against a loadable pattern under a care mask, with a saturating hit count.
module pattern_detector_param #(
  parameter int unsigned      PAT_W    = 8,
  parameter int unsigned      CNT_W    = 8,
  parameter bit               OVERLAP  = 1'b1,
  parameter logic [PAT_W-1:0] PAT_INIT = {{(PAT_W-1){1'b0}}, 1'b1}
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             w,
  input  logic             in_valid,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic [PAT_W-1:0] mask_in,
  output logic             z,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int unsigned          FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(PAT_W);

  logic [PAT_W-1:0]  pat_q, mask_q, hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              z_q, sat_q, sat_d, hit;

  // Next state for a sampled bit; only committed when in_valid is high and no load is pending.
  // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
  always_comb begin
    hist_d   = {hist_q[PAT_W-2:0], w};
    fill_inc = (fill_q == FILL_FULL) ? FILL_FULL : fill_q + 1'b1;
    hit      = (fill_inc == FILL_FULL) && (((hist_d ^ pat_q) & mask_q) == '0);
    fill_d   = (hit && !OVERLAP) ? '0 : fill_inc;
    cnt_d    = (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
    sat_d    = sat_q | (&cnt_d);
  end

  // NOTE: state registers use non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q  <= PAT_INIT;
      mask_q <= '1;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      z_q    <= 1'b0;
    end else if (pat_load) begin
      // A load restarts detection; a bit arriving in the same cycle is dropped.
      pat_q  <= pat_in;
      mask_q <= mask_in;
      hist_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      sat_q  <= 1'b0;
      z_q    <= 1'b0;
    end else if (in_valid) begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      cnt_q  <= cnt_d;
      sat_q  <= sat_d;
      z_q    <= hit;
    end else begin
      z_q <= 1'b0;
    end
  end

  assign z           = z_q;
  assign match_count = cnt_q;
  assign count_sat   = sat_q;

endmodule
